// File: rtl/medidor_ciclos_rgb_pkg.sv
// rtl/medidor_ciclos_rgb_pkg.sv - shared states, defaults and channel indices for the RGB cycle meter
package medidor_ciclos_rgb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIDE = 2'd1,
        FIN  = 2'd2
    } estado_t;

    localparam int ANCHO_DEF   = 5;
    localparam int VENTANA_DEF = 32;

    // {B,G,R} bit positions on the flag bus, shared with the timer
    localparam int CANAL_R = 0;
    localparam int CANAL_G = 1;
    localparam int CANAL_B = 2;

endpackage

// File: rtl/medidor_canal.sv
// rtl/medidor_canal.sv - per-channel high-cycle counter with edge and saturation tracking
module medidor_canal #(
    parameter int ANCHO = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             flag,
    output logic [ANCHO-1:0] cnt,
    output logic             err
);

    localparam logic [ANCHO-1:0] MAXIMO = '1;

    logic       flag_prev;
    logic       sat;
    logic [1:0] edges;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sat       <= 1'b0;
            edges     <= 2'd0;
            flag_prev <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            sat       <= 1'b0;
            edges     <= 2'd0;
            flag_prev <= 1'b0;
        end else if (en) begin
            flag_prev <= flag;
            if (flag && (cnt != MAXIMO)) begin
                cnt <= cnt + 1'b1;
                if (cnt == MAXIMO - 1'b1) begin
                    sat <= 1'b1;
                end
            end
            // flag_prev starts at 0, so a flag already high on sample one counts as an edge
            if (flag && !flag_prev && (edges != 2'd2)) begin
                edges <= edges + 2'd1;
            end
        end
    end

    assign err = edges[1] | sat;

endmodule

// File: rtl/medidor_ciclos_rgb.sv
// rtl/medidor_ciclos_rgb.sv - recovers R/G/B high-cycle counts from the timer flag lines
module medidor_ciclos_rgb
    import medidor_ciclos_rgb_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int VENTANA = VENTANA_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter,
    input  logic [2:0]       flags,
    output logic [ANCHO-1:0] ciclos_R,
    output logic [ANCHO-1:0] ciclos_G,
    output logic [ANCHO-1:0] ciclos_B,
    output logic             listo,
    output logic             ocupado,
    output logic [2:0]       error
);

    localparam int            WW     = $clog2(VENTANA + 1);
    localparam logic [WW-1:0] ULTIMO = WW'(VENTANA - 1);

    estado_t          estado, estado_sig;
    logic             enter_q;
    logic             start;
    logic             clr;
    logic             en;
    logic [WW-1:0]    wcnt;
    logic [ANCHO-1:0] cnt [3];
    logic [2:0]       err;
    logic [ANCHO-1:0] ciclos_q [3];
    logic [2:0]       error_q;

    assign start = enter & ~enter_q;
    assign clr   = start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q <= 1'b0;
            estado  <= IDLE;
        end else begin
            enter_q <= enter;
            estado  <= estado_sig;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (start) begin
            wcnt <= '0;
        end else if (estado == MIDE) begin
            wcnt <= wcnt + WW'(1);
        end
    end

    // A start while measuring restarts the window; a start in FIN is honoured after FIN
    always_comb begin
        estado_sig = estado;
        listo      = 1'b0;
        ocupado    = 1'b0;
        en         = 1'b0;
        case (estado)
            IDLE: begin
                if (start) estado_sig = MIDE;
            end
            MIDE: begin
                ocupado = 1'b1;
                en      = 1'b1;
                if (!start && (wcnt == ULTIMO)) estado_sig = FIN;
            end
            FIN: begin
                listo      = 1'b1;
                estado_sig = start ? MIDE : IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_canal
        medidor_canal #(.ANCHO(ANCHO)) u_canal (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .en   (en),
            .flag (flags[i]),
            .cnt  (cnt[i]),
            .err  (err[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) ciclos_q[i] <= '0;
            error_q <= 3'b000;
        end else if (estado == FIN) begin
            for (int i = 0; i < 3; i++) ciclos_q[i] <= cnt[i];
            error_q <= err;
        end
    end

    // Counters are frozen during FIN, so they are forwarded to make results visible with listo
    assign ciclos_R = (estado == FIN) ? cnt[CANAL_R] : ciclos_q[CANAL_R];
    assign ciclos_G = (estado == FIN) ? cnt[CANAL_G] : ciclos_q[CANAL_G];
    assign ciclos_B = (estado == FIN) ? cnt[CANAL_B] : ciclos_q[CANAL_B];
    assign error    = (estado == FIN) ? err : error_q;

endmodule

// File: tb/tb_medidor_ciclos_rgb.sv
// tb/tb_medidor_ciclos_rgb.sv - scoreboard bench for the RGB cycle meter
module tb_medidor_ciclos_rgb;

    localparam int ANCHO = 5;
    localparam int V     = 32;

    typedef struct packed {
        logic [ANCHO-1:0] r;
        logic [ANCHO-1:0] g;
        logic [ANCHO-1:0] b;
        logic [2:0]       e;
    } res_t;

    logic             clk;
    logic             rst;
    logic             enter;
    logic [2:0]       flags;
    logic [ANCHO-1:0] ciclos_R, ciclos_G, ciclos_B;
    logic             listo, ocupado;
    logic [2:0]       error;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   kc;
    res_t sb[$];
    res_t last_exp;

    medidor_ciclos_rgb #(.ANCHO(ANCHO), .VENTANA(V)) dut (
        .clk      (clk),
        .rst      (rst),
        .enter    (enter),
        .flags    (flags),
        .ciclos_R (ciclos_R),
        .ciclos_G (ciclos_G),
        .ciclos_B (ciclos_B),
        .listo    (listo),
        .ocupado  (ocupado),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chan_model(input logic [31:0] p, output logic [ANCHO-1:0] c, output logic e);
        int   ones;
        int   edg;
        logic prev;
        ones = 0; edg = 0; prev = 1'b0;
        for (int j = 0; j < V; j++) begin
            if (p[j]) begin
                ones++;
                if (!prev) edg++;
            end
            prev = p[j];
        end
        c = (ones > 31) ? 5'd31 : ones[ANCHO-1:0];
        e = (ones >= 31) || (edg >= 2);
    endfunction

    function automatic res_t model(input logic [31:0] pr, input logic [31:0] pg, input logic [31:0] pb);
        res_t             r;
        logic [ANCHO-1:0] c0, c1, c2;
        logic             e0, e1, e2;
        chan_model(pr, c0, e0);
        chan_model(pg, c1, e1);
        chan_model(pb, c2, e2);
        r.r = c0; r.g = c1; r.b = c2; r.e = {e2, e1, e0};
        return r;
    endfunction

    task automatic begin_window(input logic [31:0] pr, input logic [31:0] pg, input logic [31:0] pb, input bit preb);
        enter = 1'b1;
        flags = preb ? 3'b100 : 3'b000;
        kc    = cyc;
        sb.push_back(model(pr, pg, pb));
    endtask

    task automatic sample_window(input logic [31:0] pr, input logic [31:0] pg, input logic [31:0] pb);
        int spur, occ, held;
        spur = 0; occ = 0; held = 0;
        for (int j = 0; j < V; j++) begin
            @(posedge clk); #1;
            enter = 1'b0;
            flags = {pb[j], pg[j], pr[j]};
            @(negedge clk);
            if (listo) spur++;
            if (ocupado) occ++;
            if ({ciclos_R, ciclos_G, ciclos_B, error} !== {last_exp.r, last_exp.g, last_exp.b, last_exp.e}) held++;
        end
        @(posedge clk); #1;
        flags = 3'b000;
        checks++;
        if (spur !== 0) begin failures++; $display("FAIL listo_in_window: got %0d pulses expected 0", spur); end
        checks++;
        if (occ !== V) begin failures++; $display("FAIL ocupado_cycles: got %0d expected %0d", occ, V); end
        checks++;
        if (held !== 0) begin failures++; $display("FAIL outputs_held: got %0d changed cycles expected 0", held); end
    endtask

    task automatic await_result(input int exp_cyc);
        bit   got;
        res_t x;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (listo === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL listo_timeout: got no listo expected one at cycle %0d", exp_cyc);
        end else begin
            checks++;
            if (cyc !== exp_cyc) begin failures++; $display("FAIL listo_cycle: got %0d expected %0d", cyc, exp_cyc); end
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty: got listo expected none");
            end else begin
                x = sb.pop_front();
                checks++;
                if (ciclos_R !== x.r) begin failures++; $display("FAIL ciclos_R: got %0d expected %0d", ciclos_R, x.r); end
                checks++;
                if (ciclos_G !== x.g) begin failures++; $display("FAIL ciclos_G: got %0d expected %0d", ciclos_G, x.g); end
                checks++;
                if (ciclos_B !== x.b) begin failures++; $display("FAIL ciclos_B: got %0d expected %0d", ciclos_B, x.b); end
                checks++;
                if (error !== x.e) begin failures++; $display("FAIL error: got %b expected %b", error, x.e); end
                last_exp = x;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enter = 1'b0; flags = 3'b000;
        last_exp = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ciclos_R, ciclos_G, ciclos_B} !== '0) begin failures++; $display("FAIL reset_ciclos: got %h expected 0", {ciclos_R, ciclos_G, ciclos_B}); end
        checks++;
        if (error !== 3'b000) begin failures++; $display("FAIL reset_error: got %b expected 000", error); end
        checks++;
        if (listo !== 1'b0) begin failures++; $display("FAIL reset_listo: got %b expected 0", listo); end
        checks++;
        if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({listo, ocupado} !== 2'b00) begin failures++; $display("FAIL idle_after_reset: got %b expected 00", {listo, ocupado}); end
    endtask

    task automatic run_one(input logic [31:0] pr, input logic [31:0] pg, input logic [31:0] pb, input bit preb);
        int k0;
        @(posedge clk); #1;
        begin_window(pr, pg, pb, preb);
        k0 = kc;
        sample_window(pr, pg, pb);
        await_result(k0 + V + 1);
    endtask

    task automatic test_basic();
        run_one(32'h0000_001F, 32'h0000_03FF, 32'h0000_7FFF, 1'b0);
    endtask

    task automatic test_saturation();
        run_one(32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0);
    endtask

    task automatic test_double_pulse();
        run_one(32'h0000_0000, 32'h0000_01E7, 32'h0000_0000, 1'b0);
    endtask

    task automatic test_preflag();
        run_one(32'h0000_0000, 32'h0000_0000, 32'h0000_000F, 1'b1);
    endtask

    task automatic test_back_to_back();
        int ka, kb;
        @(posedge clk); #1;
        begin_window(32'h0000_00F0, 32'h0000_0000, 32'h0001_0001, 1'b0);
        ka = kc;
        sample_window(32'h0000_00F0, 32'h0000_0000, 32'h0001_0001);
        begin_window(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        kb = kc;
        await_result(ka + V + 1);
        sample_window(32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        await_result(kb + V + 1);
    endtask

    task automatic test_abort();
        int ka;
        @(posedge clk); #1;
        enter = 1'b1;
        flags = 3'b111;
        repeat (9) begin
            @(posedge clk); #1;
            enter = 1'b0;
        end
        @(posedge clk); #1;
        begin_window(32'h0000_0003, 32'h0000_0C00, 32'h00F0_0000, 1'b0);
        ka = kc;
        sample_window(32'h0000_0003, 32'h0000_0C00, 32'h00F0_0000);
        await_result(ka + V + 1);
    endtask

    task automatic test_reset_mid_window();
        int n_listo, c_listo, k0;
        @(posedge clk); #1;
        enter = 1'b1;
        flags = 3'b111;
        repeat (9) begin
            @(posedge clk); #1;
            enter = 1'b0;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ocupado !== 1'b0) begin failures++; $display("FAIL async_ocupado: got %b expected 0", ocupado); end
        checks++;
        if ({ciclos_R, ciclos_G, ciclos_B, error, listo} !== '0) begin
            failures++;
            $display("FAIL async_outputs: got %h expected 0", {ciclos_R, ciclos_G, ciclos_B, error, listo});
        end
        last_exp = '0;
        @(posedge clk); #1;
        rst   = 1'b0;
        flags = 3'b000;
        @(posedge clk); #1;
        enter = 1'b1;
        k0 = cyc;
        n_listo = 0; c_listo = -1;
        for (int j = 1; j <= V + 8; j++) begin
            @(posedge clk); #1;
            if (j == 10) enter = 1'b0;
            @(negedge clk);
            if (listo) begin
                n_listo++;
                c_listo = cyc;
            end
        end
        checks++;
        if (n_listo !== 1) begin failures++; $display("FAIL held_enter_listo_count: got %0d expected 1", n_listo); end
        checks++;
        if (c_listo !== k0 + V + 1) begin failures++; $display("FAIL held_enter_listo_cycle: got %0d expected %0d", c_listo, k0 + V + 1); end
        checks++;
        if ({ciclos_R, ciclos_G, ciclos_B, error} !== '0) begin
            failures++;
            $display("FAIL held_enter_result: got %h expected 0", {ciclos_R, ciclos_G, ciclos_B, error});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_double_pulse();
        test_preflag();
        test_back_to_back();
        test_abort();
        test_reset_mid_window();
        checks++;
        if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
